// File: rtl/imem_load_arbiter_if.sv
// Bundle between the loader, the core fetch port, the imem and the arbiter.
// Widths are fixed at 32 bits to match the core datapath.
interface imem_load_arbiter_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        reload;
  logic [31:0] core_pc;
  logic [31:0] instr;
  logic        core_hold;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        fetch_fault;
  logic        ld_err;

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    input  reload,
    input  core_pc,
    input  mem_rdata,
    output ld_ready,
    output instr,
    output core_hold,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    output fetch_fault,
    output ld_err
  );

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    output reload,
    output core_pc,
    output mem_rdata,
    input  ld_ready,
    input  instr,
    input  core_hold,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    input  fetch_fault,
    input  ld_err
  );
endinterface

// File: rtl/imem_load_arbiter.sv
// Shares one instruction-memory port between a program loader and the core.
// Loads words from 0 upward, then hands the port to core fetches.
module imem_load_arbiter #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           reset,
  imem_load_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST_W = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    ERR
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] wcnt_nxt;
  logic [AW-1:0] lcnt;
  logic [AW-1:0] lcnt_nxt;
  logic          err_q;
  logic          err_nxt;
  logic          loading;
  logic          hs;
  logic          in_run;
  logic          fault;

  assign loading = (state == IDLE) || (state == LOAD);
  assign hs      = bus.ld_valid && loading;
  assign in_run  = (state == RUN);

  // Fetches beyond the loaded image are faulted, not just beyond DEPTH.
  assign fault = in_run &&
                 ((bus.core_pc[1:0] != 2'b00) ||
                  (bus.core_pc[31:2] >= 30'(lcnt)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wcnt  <= '0;
      lcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      lcnt  <= lcnt_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    lcnt_nxt  = lcnt;
    err_nxt   = err_q;
    unique case (state)
      IDLE, LOAD: begin
        if (hs) begin
          wcnt_nxt = wcnt + AW'(1);
          if (bus.ld_last) begin
            state_nxt = RUN;
            lcnt_nxt  = wcnt + AW'(1);
          end else if (wcnt == LAST_W) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      RUN: begin
        if (bus.reload) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset is synchronous, so outputs are masked while it is held low.
  assign bus.ld_ready    = !reset || loading;
  assign bus.mem_we      = reset && hs;
  assign bus.mem_wdata   = bus.ld_data;
  assign bus.core_hold   = !reset || !in_run;
  assign bus.fetch_fault = reset && fault;
  assign bus.ld_err      = err_q;

  assign bus.instr = (reset && in_run && !fault) ?
                     bus.mem_rdata : NOP_INSTR;

  assign bus.mem_addr = !reset ? 32'h0 :
                        in_run ? bus.core_pc :
                        32'({wcnt, 2'b00});

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Scoreboard bench for imem_load_arbiter with a small memory model.
// Expected writes are queued at drive time and matched on mem_we.
module tb_imem_load_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_load_arbiter_if bus ();

  imem_load_arbiter #(
    .DEPTH    (32),
    .NOP_INSTR(NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [0:31];
  assign bus.mem_rdata = mem[bus.mem_addr[6:2]];
  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_addr[6:2]] <= bus.mem_wdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_w = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexp_we", 32'(bus.mem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e[63:32]);
        chk("wr_data", bus.mem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    chk("ld_ready", 32'(bus.ld_ready), 32'd1);
    exp_q.push_back({32'(exp_w * 4), d});
    exp_w++;
    tick();
  endtask

  task automatic fetch(input logic [31:0] pc,
                       input logic [31:0] ins,
                       input logic flt);
    bus.core_pc = pc;
    @(negedge clk);
    chk("instr", bus.instr, ins);
    chk("fault", 32'(bus.fetch_fault), 32'(flt));
    chk("run_hold", 32'(bus.core_hold), 32'd0);
    chk("run_rdy", 32'(bus.ld_ready), 32'd0);
    chk("run_addr", bus.mem_addr, pc);
    tick();
  endtask

  task automatic rst_outs();
    @(negedge clk);
    chk("rst_hold", 32'(bus.core_hold), 32'd1);
    chk("rst_rdy", 32'(bus.ld_ready), 32'd1);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    @(negedge clk);
    chk("idle_hold", 32'(bus.core_hold), 32'd1);
    chk("idle_rdy", 32'(bus.ld_ready), 32'd1);
    chk("idle_addr", bus.mem_addr, 32'd0);
    chk("idle_instr", bus.instr, NOP);
    tick();
    exp_w = 0;
  endtask

  task automatic gap2();
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      chk("gap_hold", 32'(bus.core_hold), 32'd1);
      chk("gap_addr", bus.mem_addr, 32'(exp_w * 4));
      tick();
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hFFFF_FFFF;
    bus.ld_last  = 1'b0;
    bus.reload   = 1'b0;
    bus.core_pc  = 32'h0;
    rst_outs();
    tick();
    tick();
    reset = 1'b1;
    quiet();
    @(negedge clk);
    chk("err_init", 32'(bus.ld_err), 32'd0);
    chk("hold_init", 32'(bus.core_hold), 32'd1);
    tick();

    send(32'h0010_0193, 1'b0);
    send(32'h0060_0293, 1'b0);
    send(32'h0002_0233, 1'b1);
    quiet();
    fetch(32'h4, 32'h0060_0293, 1'b0);
    fetch(32'h0, 32'h0010_0193, 1'b0);
    fetch(32'h8, 32'h0002_0233, 1'b0);
    fetch(32'h6, NOP, 1'b1);
    fetch(32'hC, NOP, 1'b1);
    fetch(32'h1000_0000, NOP, 1'b1);

    do_reload();
    send(32'h0000_0093, 1'b1);
    quiet();
    fetch(32'h0, 32'h0000_0093, 1'b0);
    fetch(32'h4, NOP, 1'b1);

    do_reload();
    send(32'h00a0_0093, 1'b0);
    quiet();
    gap2();
    send(32'h00b0_0113, 1'b0);
    quiet();
    gap2();
    send(32'h00c0_0193, 1'b1);
    quiet();
    fetch(32'h8, 32'h00c0_0193, 1'b0);
    fetch(32'h4, 32'h00b0_0113, 1'b0);
    fetch(32'h0, 32'h00a0_0093, 1'b0);
    fetch(32'hC, NOP, 1'b1);

    do_reload();
    send(32'h0110_0093, 1'b0);
    send(32'h0120_0093, 1'b0);
    bus.ld_data = 32'h0130_0093;
    reset       = 1'b0;
    rst_outs();
    tick();
    reset = 1'b1;
    quiet();
    exp_w = 0;
    @(negedge clk);
    chk("post_rst_addr", bus.mem_addr, 32'd0);
    chk("post_rst_hold", 32'(bus.core_hold), 32'd1);
    tick();
    send(32'h0140_0093, 1'b1);
    quiet();
    fetch(32'h0, 32'h0140_0093, 1'b0);
    fetch(32'h4, NOP, 1'b1);

    do_reload();
    for (int i = 0; i < 32; i++)
      send(32'h1000 + 32'(i), 1'b0);
    quiet();
    @(negedge clk);
    chk("ovf_err", 32'(bus.ld_err), 32'd1);
    chk("ovf_hold", 32'(bus.core_hold), 32'd1);
    chk("ovf_rdy", 32'(bus.ld_ready), 32'd0);
    chk("ovf_fault", 32'(bus.fetch_fault), 32'd0);
    chk("ovf_instr", bus.instr, NOP);
    tick();
    bus.ld_valid = 1'b1;
    bus.reload   = 1'b1;
    tick();
    tick();
    quiet();
    bus.reload = 1'b0;
    @(negedge clk);
    chk("err_sticky", 32'(bus.ld_err), 32'd1);
    chk("err_rdy", 32'(bus.ld_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("err_clr", 32'(bus.ld_err), 32'd0);
    chk("clr_rdy", 32'(bus.ld_ready), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
